// File: rtl/led_fade_ramp.sv
// led_fade_ramp: duty-cycle source for the 8-bit LED PWM stage.
//
// Accepts commands over a valid/ready handshake:
//   SET     - jump to cmd_target immediately, pulse done_pulse
//   FADE    - step by 1 toward cmd_target once per tick, pulse done_pulse
//             on the tick that finds the level already at target
//   BREATHE - bounce between cmd_target (peak) and 0, one step per tick,
//             dwelling two ticks at each endpoint, until the next command
//   STOP    - freeze the level and return to IDLE
// A tick fires every (cmd_step_div + 1) clk cycles, counted from the accept.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   cmd_valid/ready command handshake (ready low only while fading)
//   cmd_mode        00 SET, 01 FADE, 10 BREATHE, 11 STOP
//   cmd_target      SET/FADE target, BREATHE peak
//   cmd_step_div    tick interval minus one, in clk cycles
//   duty_cycle      registered level to the PWM stage
//   busy            high whenever not IDLE
//   done_pulse      one-cycle pulse on SET or FADE completion
//
// Optional feature macro: LED_FADE_GAMMA_EN
//   When defined, duty_cycle = (level*(level+1)) >> 8 through one extra
//   register stage, and done_pulse is delayed one cycle to match.

module led_fade_ramp #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [7:0]       cmd_target,
  input  logic [DIV_W-1:0] cmd_step_div,
  output logic [7:0]       duty_cycle,
  output logic             busy,
  output logic             done_pulse
);

  localparam logic [1:0] MODE_SET     = 2'b00;
  localparam logic [1:0] MODE_FADE    = 2'b01;
  localparam logic [1:0] MODE_BREATHE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FADE    = 2'd1,
    S_BR_UP   = 2'd2,
    S_BR_DOWN = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [7:0]       level, level_n;
  logic [7:0]       tgt;
  logic [DIV_W-1:0] div, cnt;
  logic             done_q, done_n;
  logic             accept, tick;

  assign cmd_ready = (state != S_FADE);
  assign busy      = (state != S_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  // An accept restarts the interval, so a tick coinciding with it is dropped.
  assign tick      = (cnt == div) & ~accept;

  // Tick counter and latched command operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      tgt <= '0;
      div <= '0;
    end else if (accept) begin
      cnt <= '0;
      tgt <= cmd_target;
      div <= cmd_step_div;
    end else if (cnt == div) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      level  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      level  <= level_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    level_n = level;
    done_n  = 1'b0;
    if (accept) begin
      case (cmd_mode)
        MODE_SET: begin
          level_n = cmd_target;
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
        MODE_FADE:    state_n = S_FADE;
        MODE_BREATHE: state_n = S_BR_UP;
        default:      state_n = S_IDLE;   // STOP: level frozen
      endcase
    end else if (tick) begin
      case (state)
        S_FADE: begin
          if (level == tgt) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else if (level < tgt) begin
            level_n = level + 8'd1;
          end else begin
            level_n = level - 8'd1;
          end
        end
        // A breathe may start above the peak, so "up" steps toward it
        // from either side.
        S_BR_UP: begin
          if (level == tgt)     state_n = S_BR_DOWN;
          else if (level < tgt) level_n = level + 8'd1;
          else                  level_n = level - 8'd1;
        end
        S_BR_DOWN: begin
          if (level == 8'd0) state_n = S_BR_UP;
          else               level_n = level - 8'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef LED_FADE_GAMMA_EN
  // 255*256 fits in 16 bits; the top byte is the gamma-corrected duty.
  logic [15:0] sq;
  logic [7:0]  gam_q;
  assign sq = {8'd0, level} * ({8'd0, level} + 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gam_q      <= '0;
      duty_cycle <= '0;
      done_pulse <= 1'b0;
    end else begin
      gam_q      <= sq[15:8];
      duty_cycle <= gam_q;
      done_pulse <= done_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) duty_cycle <= '0;
    else        duty_cycle <= level;
  end

  assign done_pulse = done_q;
`endif

endmodule

// File: tb/tb_led_fade_ramp.sv
// Testbench for led_fade_ramp (default build, gamma disabled).
// Directed scenarios with constant expectations, then randomized command
// traffic compared every cycle against a behavioural model.

module tb_led_fade_ramp;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_mode = 2'b00;
  logic [7:0]       cmd_target = 8'd0;
  logic [DIV_W-1:0] cmd_step_div = '0;
  logic [7:0]       duty_cycle;
  logic             busy;
  logic             done_pulse;

  int checks = 0;
  int failures = 0;

  led_fade_ramp #(.DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_target(cmd_target), .cmd_step_div(cmd_step_div),
    .duty_cycle(duty_cycle), .busy(busy), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  // Behavioural model. m_ph: 0 idle, 1 fading, 2 breathing toward peak,
  // 3 breathing toward zero. m_el counts cycles since the last accept; a
  // tick lands on every cycle whose index is div mod (div+1).
  int m_lvl, m_tgt, m_div, m_el, m_ph, m_duty;
  bit m_done;

  function automatic void model_reset();
    m_lvl = 0; m_tgt = 0; m_div = 0; m_el = 0; m_ph = 0; m_duty = 0; m_done = 0;
  endfunction

  function automatic void model_edge();
    int lvl = m_lvl;
    int ph  = m_ph;
    bit dn  = 0;
    bit tk;
    m_duty = m_lvl;
    if (cmd_valid && m_ph != 1) begin
      m_tgt = cmd_target;
      m_div = cmd_step_div;
      m_el  = 0;
      case (cmd_mode)
        2'd0: begin lvl = cmd_target; ph = 0; dn = 1; end
        2'd1: ph = 1;
        2'd2: ph = 2;
        default: ph = 0;
      endcase
    end else begin
      tk = (m_el % (m_div + 1)) == m_div;
      m_el++;
      if (tk) begin
        case (ph)
          1: if (lvl == m_tgt) begin ph = 0; dn = 1; end
             else lvl += (lvl < m_tgt) ? 1 : -1;
          2: if (lvl == m_tgt) ph = 3;
             else lvl += (lvl < m_tgt) ? 1 : -1;
          3: if (lvl == 0) ph = 2;
             else lvl--;
          default: ;
        endcase
      end
    end
    m_lvl = lvl; m_ph = ph; m_done = dn;
  endfunction

  // One clock: model follows the inputs as the DUT will see them, then we
  // land on the falling edge where outputs are sampled.
  task automatic step();
    if (rst_n) model_edge();
    else       model_reset();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] mode, input int tgt, input int dv);
    cmd_valid    = 1'b1;
    cmd_mode     = mode;
    cmd_target   = 8'(tgt);
    cmd_step_div = DIV_W'(dv);
    step();
    cmd_valid    = 1'b0;
    cmd_target   = 8'($urandom);
    cmd_mode     = 2'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (duty_cycle !== 8'd0 || busy !== 1'b0 || done_pulse !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_values: got duty=%0d busy=%b done=%b ready=%b expected 0/0/0/1",
               duty_cycle, busy, done_pulse, cmd_ready);
    end
  endtask

  task automatic test_set();
    send(2'd0, 8'h80, 5);
    checks++;
    if (done_pulse !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL set_done: got done=%b busy=%b expected done=1 busy=0", done_pulse, busy);
    end
    step();
    checks++;
    if (duty_cycle !== 8'h80 || done_pulse !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL set_level: got duty=%0d done=%b busy=%b expected 128/0/0",
               duty_cycle, done_pulse, busy);
    end
  endtask

  task automatic test_fade();
    int done_at = -1;
    int bad = 0;
    send(2'd0, 0, 0);
    step();
    send(2'd1, 10, 3);
    for (int k = 1; k <= 60 && done_at < 0; k++) begin
      int exp_duty;
      step();
      exp_duty = (k - 1) / 4;
      if (exp_duty > 10) exp_duty = 10;
      if (done_pulse === 1'b1) done_at = k;
      else if (cmd_ready !== 1'b0 || busy !== 1'b1 || duty_cycle !== 8'(exp_duty)) begin
        bad++;
        if (bad < 4)
          $display("FAIL fade_progress: cycle %0d got duty=%0d ready=%b busy=%b expected %0d/0/1",
                   k, duty_cycle, cmd_ready, busy, exp_duty);
      end
    end
    checks++;
    if (bad != 0) failures++;
    checks++;
    if (done_at != 44) begin
      failures++;
      $display("FAIL fade_done_latency: got %0d expected 44", done_at);
    end
    step();
    checks++;
    if (busy !== 1'b0 || duty_cycle !== 8'd10 || done_pulse !== 1'b0) begin
      failures++;
      $display("FAIL fade_end: got busy=%b duty=%0d done=%b expected 0/10/0", busy, duty_cycle, done_pulse);
    end
  endtask

  task automatic test_breathe_stop();
    int exp_seq [12] = '{0, 1, 2, 3, 4, 4, 3, 2, 1, 0, 0, 1};
    int bad = 0;
    send(2'd0, 0, 0);
    step();
    send(2'd2, 4, 0);
    for (int j = 0; j < 12; j++) begin
      step();
      checks++;
      if (duty_cycle !== 8'(exp_seq[j]) || busy !== 1'b1 || done_pulse !== 1'b0) begin
        failures++;
        $display("FAIL breathe_seq[%0d]: got duty=%0d busy=%b done=%b expected %0d/1/0",
                 j, duty_cycle, busy, done_pulse, exp_seq[j]);
      end
    end
    send(2'd3, 0, 0);
    for (int j = 0; j < 5; j++) begin
      if (duty_cycle !== 8'd2 || busy !== 1'b0 || done_pulse !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stop_hold: got %0d bad cycles, duty=%0d busy=%b expected 0 bad, 2/0",
               bad, duty_cycle, busy);
    end
  endtask

  task automatic test_preempt();
    int prev;
    int done_at = -1;
    int jumps = 0;
    send(2'd0, 0, 0);
    step();
    send(2'd2, 200, 0);
    repeat (120) step();
    send(2'd1, 50, 0);
    prev = duty_cycle;
    checks++;
    if (duty_cycle !== 8'd120) begin
      failures++;
      $display("FAIL preempt_start: got duty=%0d expected 120", duty_cycle);
    end
    for (int j = 1; j <= 300 && done_at < 0; j++) begin
      step();
      if (int'(duty_cycle) > prev || prev - int'(duty_cycle) > 1) jumps++;
      prev = duty_cycle;
      if (done_pulse === 1'b1) done_at = j;
    end
    checks++;
    if (jumps != 0) begin
      failures++;
      $display("FAIL preempt_smooth: got %0d jumps expected 0", jumps);
    end
    checks++;
    if (done_at != 71 || duty_cycle !== 8'd50) begin
      failures++;
      $display("FAIL preempt_done: got at=%0d duty=%0d expected 71/50", done_at, duty_cycle);
    end
  endtask

  task automatic test_async_reset();
    send(2'd1, 200, 0);
    repeat (20) step();
    #2;
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_mode  = 2'd0;
    cmd_target = 8'h55;
    #1;
    checks++;
    if (duty_cycle !== 8'd0 || busy !== 1'b0 || done_pulse !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: got duty=%0d busy=%b done=%b ready=%b expected 0/0/0/1",
               duty_cycle, busy, done_pulse, cmd_ready);
    end
    model_reset();
    repeat (2) @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    step();
    checks++;
    if (duty_cycle !== 8'd0 || busy !== 1'b0 || done_pulse !== 1'b0) begin
      failures++;
      $display("FAIL reset_drops_cmd: got duty=%0d busy=%b done=%b expected 0/0/0",
               duty_cycle, busy, done_pulse);
    end
  endtask

  task automatic test_random();
    int printed = 0;
    for (int n = 0; n < 4000; n++) begin
      cmd_valid    = ($urandom_range(0, 99) < 15);
      cmd_mode     = 2'($urandom);
      cmd_target   = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 12));
      cmd_step_div = DIV_W'($urandom_range(0, 3));
      step();
      checks++;
      if (duty_cycle !== 8'(m_duty) || busy !== (m_ph != 0) ||
          cmd_ready !== (m_ph != 1) || done_pulse !== m_done) begin
        failures++;
        if (printed < 10) begin
          printed++;
          $display("FAIL random[%0d]: got duty=%0d busy=%b ready=%b done=%b expected %0d/%b/%b/%b",
                   n, duty_cycle, busy, cmd_ready, done_pulse,
                   m_duty, (m_ph != 0), (m_ph != 1), m_done);
        end
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_set();
    test_fade();
    test_breathe_stop();
    test_preempt();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
